uart_tx_drain: RTL and testbench

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

---
 rtl/uart_tx_drain.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_drain.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
// FIFO-draining UART transmitter: fetches a byte when enabled, sends start, 8 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps
module uart_tx_drain #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_enable,
   input  logic       in_fifo_empty,
   input  logic [7:0] in_fifo_data,
   output logic       out_fifo_read,
   output logic       out_tx,
   output logic       out_busy,
   output logic       out_byte_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd5
   } state_t;

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        fetch_go;
   logic        bit_end;
`ifdef UART_TX_PARITY_EN
   logic        parity_q, parity_d;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction
`endif

   assign bit_end = (cnt_q == BIT_LAST);

   // Next-state, counter, shift register and look-ahead of the registered outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      fetch_go  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = 16'd0;
            if (in_enable && !in_fifo_empty) begin
               fetch_go = 1'b1;
               state_d  = S_FETCH;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_FETCH: begin
            shift_d   = in_fifo_data;
`ifdef UART_TX_PARITY_EN
            parity_d  = even_parity(in_fifo_data);
`endif
            cnt_d     = 16'd0;
            bit_idx_d = 3'd0;
            state_d   = S_START;
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = 16'd0;
               state_d = S_DATA;
            end else begin
               cnt_d   = cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d   = 16'd0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                  state_d   = S_PARITY;
`else
                  state_d   = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = 16'd0;
               state_d = S_STOP;
            end else begin
               cnt_d   = cnt_q + 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               cnt_d   = 16'd0;
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            cnt_d     = 16'd0;
            bit_idx_d = 3'd0;
            shift_d   = 8'd0;
         end
      endcase

      // Outputs are derived from the next state so the flops change exactly on bit boundaries.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_STOP) && (cnt_d == BIT_LAST);
   end

   // State and registered-output flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 16'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign out_fifo_read = fetch_go & ~rst;
   assign out_tx        = tx_q;
   assign out_busy      = busy_q;
   assign out_byte_done = done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench for uart_tx_drain: stimulus queues expected bytes, a negedge monitor receives and checks frames.
`timescale 1ns/1ps
module tb_uart_tx_drain;
   localparam int N = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_enable = 1'b0;
   logic       in_fifo_empty = 1'b1;
   logic [7:0] in_fifo_data = 8'h00;
   logic       out_fifo_read, out_tx, out_busy, out_byte_done;

   uart_tx_drain #(.CLKS_PER_BIT(N)) dut (
      .clk(clk), .rst(rst), .in_enable(in_enable), .in_fifo_empty(in_fifo_empty),
      .in_fifo_data(in_fifo_data), .out_fifo_read(out_fifo_read), .out_tx(out_tx),
      .out_busy(out_busy), .out_byte_done(out_byte_done));

   always #5 clk = ~clk;

   typedef struct { logic [7:0] data; logic par; } exp_t;
   typedef struct { string name; int kind; int expv; } req_t;

   logic [7:0] fifo_q[$];
   exp_t       exp_q[$];
   req_t       req_q[$];
   int errors = 0, checks = 0;
   int reads = 0, dones = 0, frames = 0, gaps2 = 0;

   task automatic push_byte(input logic [7:0] b, input logic p);
      exp_t e;
      e.data = b;
      e.par  = p;
      fifo_q.push_back(b);
      exp_q.push_back(e);
      in_fifo_empty = 1'b0;
   endtask

   // kinds: 0 tx, 1 busy, 2 read, 3 reads, 4 dones, 5 frames, 6 pending expected, 7 gaps of two, 8 byte_done
   task automatic expect_now(input string name, input int kind, input int expv);
      req_t r;
      r.name = name;
      r.kind = kind;
      r.expv = expv;
      req_q.push_back(r);
   endtask

   task automatic cyc();
      logic rd;
      @(negedge clk);
      rd = out_fifo_read;
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() > 0) in_fifo_data = fifo_q.pop_front();
      in_fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic wait_frames(input int target, input int budget);
      for (int i = 0; i < budget && frames < target; i++) cyc();
   endtask

   task automatic wait_start(input int budget);
      for (int i = 0; i < budget && !(out_tx == 1'b0 && out_busy == 1'b1); i++) cyc();
   endtask

   // Monitor: services directed requests and receives/verifies every serial frame cycle by cycle.
   initial begin : monitor
      logic [10:0] fbits;
      int   c, act, gap;
      bit   in_frame, bad, gap_ok;
      exp_t e;
      req_t r;
      c = 0; gap = 0; in_frame = 1'b0; bad = 1'b0; gap_ok = 1'b0;
      fbits = 11'h7ff;
      e.data = 8'h00; e.par = 1'b0;
      forever begin
         @(negedge clk);
         while (req_q.size() > 0) begin
            r = req_q.pop_front();
            case (r.kind)
               0: act = int'(out_tx);
               1: act = int'(out_busy);
               2: act = int'(out_fifo_read);
               3: act = reads;
               4: act = dones;
               5: act = frames;
               6: act = exp_q.size();
               7: act = gaps2;
               8: act = int'(out_byte_done);
               default: act = -1;
            endcase
            checks++;
            if (act != r.expv) begin
               errors++;
               $display("FAIL %s: got %0d, expected %0d", r.name, act, r.expv);
            end
         end
         if (out_fifo_read) reads++;
         if (out_byte_done) dones++;
         if (rst) begin
            in_frame = 1'b0;
            gap_ok   = 1'b0;
         end else begin
            if (!in_frame) begin
               if (out_tx == 1'b0) begin
                  if (gap_ok && gap == 2) gaps2++;
                  gap_ok = 1'b0;
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                  end else begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_frame: start bit seen, expected none pending");
                     e.data = 8'h00; e.par = 1'b0;
                  end
`ifdef UART_TX_PARITY_EN
                  fbits = {1'b1, e.par, e.data, 1'b0};
`else
                  fbits = {1'b1, 1'b1, e.data, 1'b0};
`endif
                  in_frame = 1'b1;
                  c   = 0;
                  bad = 1'b0;
               end else if (gap_ok) begin
                  gap++;
               end
            end
            if (in_frame) begin
               if (out_tx !== fbits[c / N] || out_busy !== 1'b1 ||
                   out_byte_done !== (c == NBITS * N - 1)) bad = 1'b1;
               if (c % N == N - 1) begin
                  checks++;
                  if (bad) begin
                     errors++;
                     $display("FAIL frame_bit%0d byte=%02h: tx=%0b busy=%0b done=%0b, expected tx=%0b busy=1 done=%0b",
                              c / N, e.data, out_tx, out_busy, out_byte_done, fbits[c / N],
                              (c == NBITS * N - 1));
                  end
                  bad = 1'b0;
               end
               c++;
               if (c == NBITS * N) begin
                  in_frame = 1'b0;
                  frames++;
                  gap_ok = 1'b1;
                  gap    = 0;
               end
            end
         end
      end
   end

   initial begin : stimulus
      // Reset with a byte already waiting: no strobe may escape while rst is high.
      in_enable = 1'b1;
      push_byte(8'hA5, 1'b0);
      cyc(); cyc(); cyc();
      expect_now("rst_tx", 0, 1);
      expect_now("rst_busy", 1, 0);
      expect_now("rst_read", 2, 0);
      expect_now("rst_done", 8, 0);
      cyc();
      rst = 1'b0;
      expect_now("first_read", 2, 1);
      cyc();
      wait_frames(1, 100);
      expect_now("a5_frames", 5, 1);
      expect_now("a5_dones", 4, 1);
      expect_now("a5_reads", 3, 1);
      expect_now("a5_idle_busy", 1, 0);
      cyc();

      // Empty FIFO with enable high: nothing moves.
      for (int i = 0; i < 20; i++) begin
         expect_now("empty_no_read", 2, 0);
         cyc();
      end
      expect_now("empty_tx", 0, 1);
      expect_now("empty_busy", 1, 0);
      cyc();

      // Back-to-back burst: two idle-high cycles between frames.
      push_byte(8'h01, 1'b1);
      push_byte(8'h80, 1'b1);
      push_byte(8'hFF, 1'b0);
      cyc();
      wait_frames(4, 200);
      expect_now("burst_frames", 5, 4);
      expect_now("burst_reads", 3, 4);
      expect_now("burst_dones", 4, 4);
      expect_now("burst_gaps2", 7, 2);
      cyc();
      cyc();

      // Enable dropped during START: frame completes, no new fetch until re-enabled.
      push_byte(8'h3C, 1'b0);
      wait_start(20);
      in_enable = 1'b0;
      push_byte(8'h11, 1'b0);
      wait_frames(5, 100);
      for (int i = 0; i < 15; i++) cyc();
      expect_now("gated_frames", 5, 5);
      expect_now("gated_reads", 3, 5);
      expect_now("gated_busy", 1, 0);
      cyc();
      in_enable = 1'b1;
      wait_frames(6, 100);
      expect_now("reenable_reads", 3, 6);
      cyc();
      cyc();

      // Reset during DATA bit 3 drops the byte; the next one is fetched right after release.
      push_byte(8'h5A, 1'b0);
      push_byte(8'hC3, 1'b0);
      wait_start(20);
      for (int i = 0; i < 4 * N + 1; i++) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      expect_now("abort_tx", 0, 1);
      expect_now("abort_busy", 1, 0);
      expect_now("abort_read", 2, 1);
      cyc();
      wait_frames(7, 100);
      expect_now("abort_frames", 5, 7);
      expect_now("abort_dones", 4, 7);
      expect_now("abort_reads", 3, 8);
      cyc();
      cyc();

      // 0x07 carries odd data weight, so its parity bit is 1 when parity is enabled.
      push_byte(8'h07, 1'b1);
      wait_frames(8, 100);
      for (int i = 0; i < 5; i++) cyc();
      expect_now("final_frames", 5, 8);
      expect_now("final_dones", 4, 8);
      expect_now("final_reads", 3, 9);
      expect_now("final_pending", 6, 0);
      expect_now("final_tx", 0, 1);
      cyc();
      cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
